myriscv_mem_arbiter: RTL and testbench

- Shares one 32-bit memory port between the myRiscv instruction-fetch port and its load/store data port.
- Replaces the separate `instr` / `rd_data` sources when the core targets a unified memory, such as single-port SRAM or a bus bridge.
- One transaction outstanding at a time. Request and grant are decoupled from the response.
- A watchdog counter bounds the wait for each response.

---
 rtl/myriscv_mem_arbiter.sv | 108 ++++++++++
 tb/tb_myriscv_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/myriscv_mem_arbiter.sv
// Shares one memory port between myRiscv fetch and load/store, one transaction in flight,
// with a response watchdog. Define MYRISCV_ARB_RR_EN for round-robin arbitration.
module myriscv_mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        m_req,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             pick_d;
  logic             expired;
  logic             done;
  logic             pass;

`ifdef MYRISCV_ARB_RR_EN
  logic last;

  always_comb begin
    pick_d = d_req;
    if (d_req && i_req) pick_d = ~last;
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  // A response on the final watchdog cycle wins over the abort.
  assign expired  = (state == WAIT) && !m_rvalid && (cnt == LAST_CNT);
  assign done     = (state == WAIT) && (m_rvalid || (cnt == LAST_CNT));
  assign pass     = (state != IDLE) && !expired;

  assign i_rvalid = done && !owner;
  assign d_rvalid = done && owner;
  assign err      = expired;
  assign i_rdata  = (pass && !owner) ? m_rdata : 32'h0;
  assign d_rdata  = (pass && owner)  ? m_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      cnt     <= '0;
      m_req   <= 1'b0;
      m_we    <= 4'h0;
      m_addr  <= 32'h0;
      m_wdata <= 32'h0;
`ifdef MYRISCV_ARB_RR_EN
      last    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner   <= pick_d;
            m_req   <= 1'b1;
            m_we    <= pick_d ? d_we : 4'h0;
            m_addr  <= pick_d ? d_addr : i_addr;
            m_wdata <= pick_d ? d_wdata : 32'h0;
`ifdef MYRISCV_ARB_RR_EN
            last    <= pick_d;
`endif
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_gnt) begin
            m_req <= 1'b0;
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myriscv_mem_arbiter.sv
// Randomized and directed bench for myriscv_mem_arbiter against a transaction-level model.
module tb_myriscv_mem_arbiter;
  localparam int TO = 8;
`ifdef MYRISCV_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, reset;
  logic        i_req, i_rvalid, d_req, d_rvalid, err, m_req, m_gnt, m_rvalid;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  d_we, m_we;

  int checks = 0;
  int errors = 0;
  bit last_m = 1'b0;
  bit got_d;

  myriscv_mem_arbiter #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    @(negedge clk);
    chk1({tag, "_mreq"}, m_req, 1'b0);
    chk1({tag, "_irv"}, i_rvalid, 1'b0);
    chk1({tag, "_drv"}, d_rvalid, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  task automatic all_zero(input string tag);
    quiet(tag);
    chk32({tag, "_mwe"}, {28'h0, m_we}, 32'h0);
    chk32({tag, "_maddr"}, m_addr, 32'h0);
    chk32({tag, "_mwdata"}, m_wdata, 32'h0);
    chk32({tag, "_irdata"}, i_rdata, 32'h0);
    chk32({tag, "_drdata"}, d_rdata, 32'h0);
  endtask

  // Called in an IDLE cycle with requests presented; returns in the following IDLE cycle.
  // s = gnt stall cycles, r = WAIT index of the response (>= TO means none arrives).
  task automatic serve(input int s, input int r, input logic [31:0] rd, input bit renew,
                       output bit got);
    logic        w, resp, abort, exp_v;
    logic [3:0]  ewe;
    logic [31:0] ea, ewd;
    w      = (i_req && d_req) ? (RR ? !last_m : 1'b1) : d_req;
    last_m = w;
    ewe    = w ? d_we : 4'h0;
    ea     = w ? d_addr : i_addr;
    ewd    = d_wdata;
    got    = 1'b0;
    m_gnt = 1'b0; m_rvalid = 1'b0;
    quiet("idle");
    next_cycle();
    for (int k = 0; k <= s; k++) begin
      m_gnt    = (k == s);
      m_rvalid = (k < s) && ($urandom_range(0, 3) == 0);
      m_rdata  = $urandom;
      @(negedge clk);
      chk1("issue_mreq", m_req, 1'b1);
      chk32("issue_maddr", m_addr, ea);
      chk32("issue_mwe", {28'h0, m_we}, {28'h0, ewe});
      if (w) chk32("issue_mwdata", m_wdata, ewd);
      chk1("issue_irv", i_rvalid, 1'b0);
      chk1("issue_drv", d_rvalid, 1'b0);
      next_cycle();
    end
    for (int k = 0; k < TO; k++) begin
      resp     = (k == r);
      abort    = (k == TO - 1) && !resp;
      exp_v    = resp || abort;
      m_rvalid = resp;
      m_rdata  = resp ? rd : $urandom;
      m_gnt    = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      chk1("wait_mreq", m_req, 1'b0);
      chk1("wait_irv", i_rvalid, exp_v && !w);
      chk1("wait_drv", d_rvalid, exp_v && w);
      chk1("wait_err", err, abort);
      if (exp_v) begin
        got = d_rvalid;
        chk32("resp_rdata", w ? d_rdata : i_rdata, resp ? rd : 32'h0);
        chk32("resp_other_rdata", w ? i_rdata : d_rdata, 32'h0);
      end
      next_cycle();
      if (exp_v) break;
    end
    m_rvalid = 1'b0;
    m_gnt    = 1'b0;
    if (!renew) begin
      if (w) d_req = 1'b0;
      else   i_req = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = 32'h0; d_addr = 32'h0;
    d_we = 4'h0; d_wdata = 32'h0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h12345678;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    all_zero("reset");
    next_cycle();

    // Fetch read
    i_req = 1'b1; i_addr = 32'h100;
    serve(0, 0, 32'h00500093, 1'b0, got_d);
    chk1("fetch_owner", got_d, 1'b0);

    // Store with three stalled issue cycles
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
    serve(3, 0, 32'h0, 1'b0, got_d);
    chk1("store_owner", got_d, 1'b1);

    // Contention, both requesters keep renewing
    i_req = 1'b1; i_addr = 32'h180; d_req = 1'b1; d_we = 4'h0; d_addr = 32'h3000;
    for (int k = 0; k < 4; k++) begin
      serve(0, 1, 32'hA0 + k, 1'b1, got_d);
      chk1($sformatf("contention_%0d", k), got_d, RR ? (k % 2 == 1) : 1'b1);
    end
    i_req = 1'b0; d_req = 1'b0;
    next_cycle();

    // Timeout, then a late response must be ignored
    i_req = 1'b1; i_addr = 32'h400;
    serve(0, 100, 32'h0, 1'b0, got_d);
    m_rvalid = 1'b1; m_rdata = 32'h55AA55AA;
    quiet("late1");
    next_cycle();
    quiet("late2");
    m_rvalid = 1'b0;
    next_cycle();

    // Reset while waiting for a response
    i_req = 1'b1; i_addr = 32'h300;
    next_cycle();
    m_gnt = 1'b1;
    next_cycle();
    m_gnt = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
    last_m = 1'b0;
    all_zero("midreset");
    next_cycle();
    quiet("midreset_rv");
    m_rvalid = 1'b0;
    next_cycle();
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h0000_0804;
    serve(1, 2, 32'h0BADF00D, 1'b0, got_d);
    chk1("after_reset_owner", got_d, 1'b1);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      if (!i_req && !d_req) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      serve($urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom,
            $urandom_range(0, 4) == 0, got_d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
